// File: rtl/cat_apb_regs.sv
// cat_apb_regs: APB register bank with a pixel FIFO draining to image memory and recognizer core start/status.
// Optional macro CAT_APB_PSLVERR_EN reports illegal accesses on pslverr; when undefined pslverr is tied low.
module cat_apb_regs #(
   parameter int DATA_W     = 32,
   parameter int PIX_W      = 8,
   parameter int IMG_AW     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              pclock,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [7:0]        paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic              wr_en,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr,
   output logic              core_start,
   input  logic              core_done,
   input  logic              core_result,
   output logic              img_valid,
   input  logic              img_ready,
   output logic [IMG_AW-1:0] img_addr,
   output logic [PIX_W-1:0]  img_data
);

   localparam int FA_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W = FA_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [2:0] IDX_CTRL    = 3'd0;
   localparam logic [2:0] IDX_STATUS  = 3'd1;
   localparam logic [2:0] IDX_PTR     = 3'd2;
   localparam logic [2:0] IDX_DATA    = 3'd3;
   localparam logic [2:0] IDX_SCRATCH = 3'd4;

   typedef enum logic [1:0] {IDLE, START, BUSY} core_state_t;

   core_state_t       state_reg, state_next;
   logic [IMG_AW-1:0] img_ptr_reg;
   logic [DATA_W-1:0] scratch_reg;
   logic              done_reg, ovf_reg, result_reg;
   logic [FA_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;

   logic [IMG_AW-1:0] entry_addr [FIFO_DEPTH];
   logic [PIX_W-1:0]  entry_data [FIFO_DEPTH];

   logic [2:0] idx;
   logic       wr_ctrl, wr_status, wr_ptr_w, wr_data, wr_scratch;
   logic       soft_clr, start_req, busy;
   logic       fifo_empty, fifo_full, pop, push, drop, done_set;
   logic       rd_access;
   logic [DATA_W-1:0] status_word;

   wire unused_paddr = &{1'b0, paddr[7:5], paddr[1:0]};

   assign idx        = paddr[4:2];
   assign wr_ctrl    = wr_en && (idx == IDX_CTRL);
   assign wr_status  = wr_en && (idx == IDX_STATUS);
   assign wr_ptr_w   = wr_en && (idx == IDX_PTR);
   assign wr_data    = wr_en && (idx == IDX_DATA);
   assign wr_scratch = wr_en && (idx == IDX_SCRATCH);
   assign soft_clr   = wr_ctrl && pwdata[1];
   assign start_req  = wr_ctrl && pwdata[0];
   assign busy       = (state_reg != IDLE);

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == DEPTH_C);
   // A pop frees the slot before the push is judged, so full+pop still accepts the push.
   assign pop        = !fifo_empty && img_ready;
   assign push       = wr_data && (!fifo_full || pop);
   assign drop       = wr_data && fifo_full && !pop;
   assign done_set   = (state_reg == BUSY) && core_done;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_req && fifo_empty) state_next = START;
         START:   state_next = BUSY;
         BUSY:    if (core_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pclock or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         img_ptr_reg <= '0;
         scratch_reg <= '0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         result_reg  <= 1'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (done_set)
            result_reg <= core_result;
         // Completion from the core takes priority over any same-cycle clear.
         if (done_set)
            done_reg <= 1'b1;
         else if (soft_clr || (wr_status && pwdata[1]))
            done_reg <= 1'b0;
         if (drop)
            ovf_reg <= 1'b1;
         else if (soft_clr || (wr_status && pwdata[3]))
            ovf_reg <= 1'b0;
         if (wr_scratch)
            scratch_reg <= pwdata;
         if (soft_clr) begin
            img_ptr_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
         end else begin
            if (wr_ptr_w)
               img_ptr_reg <= pwdata[IMG_AW-1:0];
            else if (push)
               img_ptr_reg <= img_ptr_reg + 1'b1;
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [IMG_AW-1:0] addr_reg;
         logic [PIX_W-1:0]  data_reg;
         always_ff @(posedge pclock or negedge rst) begin
            if (!rst) begin
               addr_reg <= '0;
               data_reg <= '0;
            end else if (push && (wr_ptr_reg == FA_W'(gi))) begin
               addr_reg <= img_ptr_reg;
               data_reg <= pwdata[PIX_W-1:0];
            end
         end
         assign entry_addr[gi] = addr_reg;
         assign entry_data[gi] = data_reg;
      end
   endgenerate

   assign img_valid  = !fifo_empty;
   assign img_addr   = fifo_empty ? '0 : entry_addr[rd_ptr_reg];
   assign img_data   = fifo_empty ? '0 : entry_data[rd_ptr_reg];
   assign core_start = (state_reg == START);

   always_comb begin
      status_word      = '0;
      status_word[0]   = busy;
      status_word[1]   = done_reg;
      status_word[2]   = result_reg;
      status_word[3]   = ovf_reg;
      status_word[6:4] = 3'(count_reg);
   end

   assign rd_access = psel && penable && !pwrite;

   always_comb begin
      prdata = '0;
      if (rd_access) begin
         case (idx)
            IDX_STATUS:  prdata = status_word;
            IDX_PTR:     prdata = DATA_W'(img_ptr_reg);
            IDX_SCRATCH: prdata = scratch_reg;
            default:     prdata = '0;
         endcase
      end
   end

`ifdef CAT_APB_PSLVERR_EN
   always_comb begin
      pslverr = 1'b0;
      if (psel && penable) begin
         if (idx > IDX_SCRATCH)
            pslverr = 1'b1;
         else if (pwrite && (idx == IDX_STATUS) && !pwdata[1] && !pwdata[3])
            pslverr = 1'b1;
         else if (pwrite && (idx == IDX_DATA) && fifo_full)
            pslverr = 1'b1;
         else if (pwrite && (idx == IDX_CTRL) && pwdata[0] && busy)
            pslverr = 1'b1;
      end
   end
`else
   assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_cat_apb_regs.sv
// Testbench for cat_apb_regs: register vectors, hand-written corner sequences and a randomized run
// checked every cycle against a queue-based reference model.
module tb_cat_apb_regs;

   localparam int DATA_W = 32;
   localparam int PIX_W  = 8;
   localparam int IMG_AW = 12;
   localparam int DEPTH  = 4;

   logic              pclock;
   logic              rst;
   logic              psel, penable, pwrite, wr_en;
   logic [7:0]        paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pslverr, core_start, core_done, core_result;
   logic              img_valid, img_ready;
   logic [IMG_AW-1:0] img_addr;
   logic [PIX_W-1:0]  img_data;

   cat_apb_regs #(.DATA_W(DATA_W), .PIX_W(PIX_W), .IMG_AW(IMG_AW), .FIFO_DEPTH(DEPTH)) dut (
      .pclock(pclock), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .wr_en(wr_en), .prdata(prdata), .pslverr(pslverr),
      .core_start(core_start), .core_done(core_done), .core_result(core_result),
      .img_valid(img_valid), .img_ready(img_ready), .img_addr(img_addr), .img_data(img_data)
   );

   initial pclock = 1'b0;
   always #5 pclock = ~pclock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [IMG_AW-1:0] a;
      logic [PIX_W-1:0]  d;
   } pix_t;

   pix_t              m_q[$];
   pix_t              got_q[$];
   logic [IMG_AW-1:0] m_ptr;
   logic [31:0]       m_scr;
   logic              m_done, m_ovf, m_res;
   int                m_phase;        // 0 idle, 1 start pulse, 2 waiting for core
   int                start_pulses;

   function automatic logic [31:0] m_read(input logic [2:0] i);
      logic [31:0] s;
      s = 32'd0;
      case (i)
         3'd1: begin
            s[0]   = (m_phase != 0);
            s[1]   = m_done;
            s[2]   = m_res;
            s[3]   = m_ovf;
            s[6:4] = 3'(m_q.size());
         end
         3'd2:    s = 32'(m_ptr);
         3'd4:    s = m_scr;
         default: s = 32'd0;
      endcase
      return s;
   endfunction

   always @(negedge pclock) begin : model
      logic [2:0]  ai;
      logic [31:0] exp_rd;
      logic        exp_err, was_empty, pop, done_evt;
      ai = paddr[4:2];
      if (!rst) begin
         m_q.delete();
         m_ptr   = '0;
         m_scr   = '0;
         m_done  = 1'b0;
         m_ovf   = 1'b0;
         m_res   = 1'b0;
         m_phase = 0;
         chk("reset_outputs", {img_valid, core_start, pslverr, img_addr, img_data, prdata}, 64'd0);
      end else begin
         exp_rd  = (psel && penable && !pwrite) ? m_read(ai) : 32'd0;
         exp_err = 1'b0;
`ifdef CAT_APB_PSLVERR_EN
         if (psel && penable) begin
            if (ai >= 3'd5) exp_err = 1'b1;
            else if (pwrite && ai == 3'd1 && !pwdata[1] && !pwdata[3]) exp_err = 1'b1;
            else if (pwrite && ai == 3'd3 && m_q.size() == DEPTH) exp_err = 1'b1;
            else if (pwrite && ai == 3'd0 && pwdata[0] && m_phase != 0) exp_err = 1'b1;
         end
`endif
         chk("img_valid", img_valid, m_q.size() != 0);
         if (m_q.size() != 0) begin
            chk("img_addr", img_addr, m_q[0].a);
            chk("img_data", img_data, m_q[0].d);
         end
         chk("core_start", core_start, m_phase == 1);
         chk("prdata", prdata, exp_rd);
         chk("pslverr", pslverr, exp_err);
         if (core_start) start_pulses++;
         if (img_valid && img_ready) got_q.push_back('{a: img_addr, d: img_data});

         // Predict the effect of the coming clock edge.
         was_empty = (m_q.size() == 0);
         pop       = !was_empty && img_ready;
         done_evt  = 1'b0;
         if (m_phase == 0) begin
            if (wr_en && ai == 3'd0 && pwdata[0] && was_empty) m_phase = 1;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (core_done) begin
            m_phase  = 0;
            done_evt = 1'b1;
            m_res    = core_result;
         end
         if (pop) m_q.delete(0);
         if (wr_en) begin
            case (ai)
               3'd0: if (pwdata[1]) begin
                  m_q.delete();
                  m_ptr  = '0;
                  m_done = 1'b0;
                  m_ovf  = 1'b0;
               end
               3'd1: begin
                  if (pwdata[1]) m_done = 1'b0;
                  if (pwdata[3]) m_ovf = 1'b0;
               end
               3'd2: m_ptr = pwdata[IMG_AW-1:0];
               3'd3: if (m_q.size() < DEPTH) begin
                  m_q.push_back('{a: m_ptr, d: pwdata[PIX_W-1:0]});
                  m_ptr = m_ptr + 1'b1;
               end else begin
                  m_ovf = 1'b1;
               end
               3'd4: m_scr = pwdata;
               default: ;
            endcase
         end
         if (done_evt) m_done = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge pclock);
      #1;
   endtask

   task automatic apb_write(input logic [2:0] i, input logic [31:0] d);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; wr_en = 1'b0;
      paddr = {3'b000, i, 2'b00}; pwdata = d;
      tick();
      penable = 1'b1; wr_en = 1'b1;
      tick();
      psel = 1'b0; penable = 1'b0; wr_en = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] i, output logic [31:0] d, output logic e);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; wr_en = 1'b0;
      paddr = {3'b000, i, 2'b00};
      tick();
      penable = 1'b1;
      @(negedge pclock);
      d = prdata;
      e = pslverr;
      tick();
      psel = 1'b0; penable = 1'b0;
   endtask

   function automatic logic [31:0] got_at(input int k);
      if (k < got_q.size()) return {12'd0, got_q[k].a, got_q[k].d};
      return 32'hFFFF_FFFF;
   endfunction

   typedef struct {
      logic        wr;
      logic [2:0]  idx;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] rd;
      logic        re;
      int          n55;

      vecs[0]  = '{1'b1, 3'd4, 32'hDEADBEEF, 32'h0,        "scratch_w"};
      vecs[1]  = '{1'b0, 3'd4, 32'h0,        32'hDEADBEEF, "scratch_r"};
      vecs[2]  = '{1'b1, 3'd2, 32'h00001ABC, 32'h0,        "ptr_w"};
      vecs[3]  = '{1'b0, 3'd2, 32'h0,        32'h00000ABC, "ptr_r"};
      vecs[4]  = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0,        "idx5_w"};
      vecs[5]  = '{1'b0, 3'd5, 32'h0,        32'h0,        "idx5_r"};
      vecs[6]  = '{1'b0, 3'd7, 32'h0,        32'h0,        "idx7_r"};
      vecs[7]  = '{1'b0, 3'd0, 32'h0,        32'h0,        "ctrl_r"};
      vecs[8]  = '{1'b0, 3'd3, 32'h0,        32'h0,        "imgdata_r"};
      vecs[9]  = '{1'b0, 3'd1, 32'h0,        32'h0,        "status_r"};
      vecs[10] = '{1'b1, 3'd1, 32'h0000000A, 32'h0,        "status_w1c"};
      vecs[11] = '{1'b1, 3'd4, 32'h00000001, 32'h0,        "scratch_w2"};
      vecs[12] = '{1'b0, 3'd4, 32'h0,        32'h00000001, "scratch_r2"};

      rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; wr_en = 1'b0;
      paddr = 8'd0; pwdata = 32'd0; core_done = 1'b0; core_result = 1'b0;
      img_ready = 1'b0; start_pulses = 0;
      tick();
      tick();

      // Reads while held in reset all return zero.
      for (int i = 0; i < 8; i++) begin
         apb_read(3'(i), rd, re);
         chk($sformatf("rst_read_idx%0d", i), rd, 32'd0);
      end
      rst = 1'b1;
      apb_read(3'd4, rd, re);
      chk("post_rst_scratch", rd, 32'd0);

      for (int v = 0; v < 13; v++) begin
         if (vecs[v].wr) apb_write(vecs[v].idx, vecs[v].wdata);
         else begin
            apb_read(vecs[v].idx, rd, re);
            chk(vecs[v].name, rd, vecs[v].exp);
         end
      end

      // Pointer wrap at the top of image memory.
      img_ready = 1'b1;
      apb_write(3'd2, 32'h0000_0FFE);
      got_q.delete();
      apb_write(3'd3, 32'h11);
      apb_write(3'd3, 32'h22);
      apb_write(3'd3, 32'h33);
      repeat (3) tick();
      chk("wrap_pop_count", got_q.size(), 3);
      chk("wrap_pix0", got_at(0), {12'd0, 12'hFFE, 8'h11});
      chk("wrap_pix1", got_at(1), {12'd0, 12'hFFF, 8'h22});
      chk("wrap_pix2", got_at(2), {12'd0, 12'h000, 8'h33});
      apb_read(3'd2, rd, re);
      chk("wrap_ptr", rd, 32'h001);

      // Overflow: five pushes into a stalled FIFO of four.
      img_ready = 1'b0;
      got_q.delete();
      for (int k = 1; k <= 5; k++) apb_write(3'd3, 32'h50 + 32'(k));
      apb_read(3'd1, rd, re);
      chk("ovf_status", rd, 32'h48);
      img_ready = 1'b1;
      repeat (6) tick();
      chk("ovf_drain_count", got_q.size(), 4);
      n55 = 0;
      foreach (got_q[k]) if (got_q[k].d == 8'h55) n55++;
      chk("ovf_dropped_pixel", n55, 0);
      apb_write(3'd1, 32'h8);
      apb_read(3'd1, rd, re);
      chk("ovf_w1c_bit3", rd[3], 1'b0);
      chk("ovf_w1c_status", rd, 32'h0);

      // Core start / busy / done.
      start_pulses = 0;
      apb_write(3'd0, 32'h1);
      repeat (3) tick();
      chk("start_one_pulse", start_pulses, 1);
      apb_read(3'd1, rd, re);
      chk("busy_status", rd, 32'h1);
      apb_write(3'd0, 32'h1);
      repeat (3) tick();
      chk("start_ignored_busy", start_pulses, 1);
      core_done = 1'b1; core_result = 1'b1;
      tick();
      core_done = 1'b0; core_result = 1'b0;
      apb_read(3'd1, rd, re);
      chk("done_status", rd, 32'h6);

      // Asynchronous reset mid-drain.
      img_ready = 1'b0;
      apb_write(3'd3, 32'hA1);
      apb_write(3'd3, 32'hA2);
      tick();
      chk("pre_rst_valid", img_valid, 1'b1);
      rst = 1'b0;
      #1;
      chk("async_rst_valid", img_valid, 1'b0);
      chk("async_rst_start", core_start, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      apb_read(3'd1, rd, re);
      chk("post_rst_status", rd, 32'h0);

      // Unmapped access error reporting.
      apb_read(3'd6, rd, re);
      chk("idx6_prdata", rd, 32'h0);
`ifdef CAT_APB_PSLVERR_EN
      chk("idx6_pslverr", re, 1'b1);
`else
      chk("idx6_pslverr", re, 1'b0);
`endif

      // Randomized traffic; every cycle is checked by the model.
      for (int n = 0; n < 400; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         img_ready = ($urandom_range(0, 3) != 0);
         case (op)
            0, 1, 2, 3: apb_write(3'd3, $urandom);
            4:          apb_write(3'd0, 32'($urandom_range(0, 3)));
            5:          apb_write(3'd1, 32'($urandom_range(0, 15)));
            6:          apb_write(3'd2, $urandom);
            7:          apb_write(3'($urandom_range(0, 7)), $urandom);
            default:    apb_read(3'($urandom_range(0, 7)), rd, re);
         endcase
         core_done   = ($urandom_range(0, 3) == 0);
         core_result = 1'($urandom_range(0, 1));
         tick();
         core_done = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
